summator: RTL and testbench
===========================

Name: summator

Overview:
- Parameterised unsigned adder with a registered output.
- Adds two `reglength`-bit operands and presents a `reglength+1`-bit sum (carry-out is the MSB) after a fixed clock latency.
- Leaf arithmetic block for datapaths that need a full-width, never-overflowing sum on a clock edge.
- Built as an explicit ripple-carry chain of full-adder cells, not an inferred `+`.

Parameters:
- reglength, 3, operand width in bits; legal range 1..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- r1  input  reglength  first unsigned operand.
- r2  input  reglength  second unsigned operand.
- sum  output  reglength+1  registered unsigned sum r1+r2; bit [reglength] is the carry-out.

Behaviour:
- One clock (`clk`); reset is synchronous and active-high (`reset`); no asynchronous paths.
- `reset` sampled high on a rising edge forces `sum` to 0 at that edge.
  - Any internal pipeline registers are also cleared.
- Reset takes priority over any new operand capture at the same edge.
- Combinational core: ripple chain of `reglength` full-adder cells.
  - Cell 0 carry-in is tied to 0.
  - Cell i computes s[i] = a^b^cin and cout = ab | cin(a^b).
  - The final carry drives bit [reglength] of the sum.
- Base latency is 1 cycle.
  - `sum` registered at edge N reflects r1/r2 as they were stable before edge N.
  - Result is valid one edge after the inputs settle.
- No handshake; the block computes every cycle (free-running).
  - Inputs changing every cycle produce a new result every cycle (full throughput).
- Arithmetic is unsigned only.
  - The sum never wraps: max = 2*(2^reglength - 1) = 2^(reglength+1) - 2.
  - Example at reglength=3: 7+7 = 14 = 4'b1110.
- Boundary conditions:
  - 0+0 = 0.
  - Carry propagates through every cell: 1+(2^reglength - 1) = 2^reglength.
  - Operand values are always in range; there are no illegal inputs.
- Reset mid-stream:
  - `sum` reads 0 on the reset edge.
  - The first valid result appears `latency` cycles after `reset` deasserts.
- `sum` holds its value between edges; no glitches on the output.

Optional Feature:
- Macro: SUMMATOR_INREG_EN.
- Defined:
  - r1/r2 are captured into input registers, then the adder result is registered into `sum`.
  - Latency is 2 cycles; throughput stays one result per cycle.
  - Reset clears both stages.
  - Improves timing for large `reglength`.
- Undefined:
  - The adder is fed directly from ports; latency is 1 cycle.
- Any consumer must wait at least 2 cycles after changing operands to be correct in both builds.

Decomposition:
- Shared package `summator_pkg` holds:
  - the localparam function for result width (reglength+1);
  - the latency constant, which is 1 or 2 depending on SUMMATOR_INREG_EN.
- One natural sub-module: `full_adder` (1-bit inputs a, b, cin; outputs s, cout).
  - Instantiated `reglength` times in a generate loop inside summator.

Test Plan:
- Reset: drive r1=5, r2=6 and assert `reset` for 2 edges -> `sum`=0 while reset is high; `sum`=11 the configured latency after deassertion.
- Zero and identity: 0+0 -> 0; 0+7 -> 7; 7+0 -> 7 (reglength=3).
- Maximum and full carry ripple: 7+7 -> 14; 1+7 -> 8, checking bit 3 is set and bits 2..0 are 0.
- Exhaustive: all 64 pairs at reglength=3, holding each pair for 2 cycles -> `sum` == r1+r2 in both macro builds.
- Back-to-back throughput: change operands every cycle (3+4, 6+6, 2+1) -> `sum` sequence 7, 12, 3, each appearing exactly `latency` cycles after its inputs.
- Width scaling at reglength=8: 255+255 -> 510; 128+128 -> 256.

Source files
------------

// File: rtl/summator_pkg.sv
// Shared constants for the summator: result width and pipeline latency.
// SUMMATOR_INREG_EN adds an input register stage (latency 2 instead of 1).
package summator_pkg;

  function automatic int result_w(input int reglength);
    return reglength + 1;
  endfunction

`ifdef SUMMATOR_INREG_EN
  localparam int LATENCY = 2;
`else
  localparam int LATENCY = 1;
`endif

endpackage

// File: rtl/summator_full_adder.sv
// One-bit full adder cell; summator chains reglength of these as a ripple-carry adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/summator.sv
// Registered unsigned ripple-carry adder: sum = r1 + r2 with carry-out in the MSB.
// Define SUMMATOR_INREG_EN to register the operands first (latency 2, full throughput).
module summator
  import summator_pkg::*;
#(
  parameter int reglength = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [reglength-1:0]             r1,
  input  logic [reglength-1:0]             r2,
  output logic [result_w(reglength)-1:0]   sum
);

  localparam int SUM_W = result_w(reglength);

  logic [reglength-1:0] a_p0;
  logic [reglength-1:0] b_p0;

`ifdef SUMMATOR_INREG_EN
  // Stage p0: operand capture
  logic [reglength-1:0] a_p0_d, a_p0_q;
  logic [reglength-1:0] b_p0_d, b_p0_q;

  always_comb begin
    a_p0_d = r1;
    b_p0_d = r2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_p0_q <= '0;
      b_p0_q <= '0;
    end else begin
      a_p0_q <= a_p0_d;
      b_p0_q <= b_p0_d;
    end
  end

  assign a_p0 = a_p0_q;
  assign b_p0 = b_p0_q;
`else
  assign a_p0 = r1;
  assign b_p0 = r2;
`endif

  // Carries live in per-cell nets so the chain is not one self-feeding vector.
  logic [reglength-1:0] s_bits;

  for (genvar i = 0; i < reglength; i++) begin : g_cell
    logic cin;
    logic cout;
    if (i == 0) begin : g_first
      assign cin = 1'b0;
    end else begin : g_rest
      assign cin = g_cell[i-1].cout;
    end
    full_adder u_fa (
      .a   (a_p0[i]),
      .b   (b_p0[i]),
      .cin (cin),
      .s   (s_bits[i]),
      .cout(cout)
    );
  end

  // Stage p1: registered result
  logic [SUM_W-1:0] sum_p1_d, sum_p1_q;

  always_comb begin
    sum_p1_d = {g_cell[reglength-1].cout, s_bits};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_p1_q <= '0;
    end else begin
      sum_p1_q <= sum_p1_d;
    end
  end

  assign sum = sum_p1_q;

endmodule

// File: tb/tb_summator.sv
// Self-checking bench for summator at reglength=3 and reglength=8, valid in both
// SUMMATOR_INREG_EN builds.
module tb_summator;

`ifdef SUMMATOR_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] r1a, r2a;
  logic [3:0] suma;
  logic [7:0] r1b, r2b;
  logic [8:0] sumb;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  summator #(.reglength(3)) u_dut3 (
    .clk  (clk),
    .reset(reset),
    .r1   (r1a),
    .r2   (r2a),
    .sum  (suma)
  );

  summator #(.reglength(8)) u_dut8 (
    .clk  (clk),
    .reset(reset),
    .r1   (r1b),
    .r2   (r2b),
    .sum  (sumb)
  );

  function automatic int ref_sum(input int a, input int b);
    return a + b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic hold3(input string tag, input int a, input int b);
    r1a = 3'(a);
    r2a = 3'(b);
    repeat (2) tick();
    check(tag, 32'(suma), 32'(ref_sum(a, b)));
  endtask

  task automatic hold8(input string tag, input int a, input int b);
    r1b = 8'(a);
    r2b = 8'(b);
    repeat (2) tick();
    check(tag, 32'(sumb), 32'(ref_sum(a, b)));
  endtask

  // New operands every cycle; each result must land exactly LAT edges after its inputs.
  task automatic run_stream(input string tag, input int n, input bit with_head);
    int ha[3] = '{3, 6, 2};
    int hb[3] = '{4, 6, 1};
    exp_q.delete();
    for (int k = 0; k < n + LAT; k++) begin
      if (k < n) begin
        if (with_head && k < 3) begin
          r1a = 3'(ha[k]);
          r2a = 3'(hb[k]);
        end else begin
          r1a = 3'($urandom_range(0, 7));
          r2a = 3'($urandom_range(0, 7));
        end
      end
      exp_q.push_back(ref_sum(int'(r1a), int'(r2a)));
      tick();
      if (exp_q.size() == LAT) check(tag, 32'(suma), 32'(exp_q.pop_front()));
    end
  endtask

  initial begin
    logic [3:0] s_tmp;

    reset = 1'b1;
    r1a = 3'd5;
    r2a = 3'd6;
    r1b = 8'd200;
    r2b = 8'd100;
    tick();
    check("reset_edge1", 32'(suma), 32'd0);
    check("reset_edge1_w8", 32'(sumb), 32'd0);
    tick();
    check("reset_edge2", 32'(suma), 32'd0);
    reset = 1'b0;
    repeat (LAT) tick();
    check("after_reset_5p6", 32'(suma), 32'(ref_sum(5, 6)));

    hold3("zero_0p0", 0, 0);
    hold3("ident_0p7", 0, 7);
    hold3("ident_7p0", 7, 0);
    hold3("max_7p7", 7, 7);
    hold3("ripple_1p7", 1, 7);
    s_tmp = suma;
    check("ripple_carry_bit", 32'(s_tmp[3]), 32'd1);
    check("ripple_low_bits", 32'(s_tmp[2:0]), 32'd0);

    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        hold3("exhaustive", a, b);
      end
    end

    run_stream("b2b_stream", 40, 1'b1);

    r1a = 3'($urandom_range(0, 7));
    r2a = 3'($urandom_range(0, 7));
    reset = 1'b1;
    tick();
    check("midstream_reset", 32'(suma), 32'd0);
    reset = 1'b0;
    run_stream("post_reset_stream", 30, 1'b0);

    hold8("w8_255p255", 255, 255);
    hold8("w8_128p128", 128, 128);
    hold8("w8_1p255", 1, 255);
    hold8("w8_0p0", 0, 0);
    for (int k = 0; k < 20; k++) begin
      hold8("w8_random", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
